// File: rtl/mult_share_pkg.sv
// Shared constants and types for the multiplier-sharing controller.
package mult_share_pkg;

    localparam int unsigned MULT_LAT = 4;

    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the default configuration: 4 requesters, 8-bit operands.
    localparam int unsigned RSP_ID_W   = 2;
    localparam int unsigned RSP_DATA_W = 16;

    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/mult.sv
// Four-stage pipelined unsigned multiplier with no stall input.
module mult #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   result
);

    logic [DATA_W-1:0]   a_q, b_q;
    logic [2*DATA_W-1:0] p1_q, p2_q, p3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            p1_q <= (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
            p2_q <= p1_q;
            p3_q <= p2_q;
        end
    end

    assign result = p3_q;

endmodule

// File: rtl/mult_share_rsp_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; simultaneous push/pop legal at any level.
module mult_share_rsp_fifo #(
    parameter  int unsigned Width = 18,
    parameter  int unsigned Depth = 8,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign count_o = count_q;
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Upstream credit accounting must make this unreachable.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_i && !pop_i && count_q == CntW'(Depth)))
                else $error("rsp fifo overflow");
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one pipelined multiplier; results return id-tagged through a
// credit-protected response FIFO.
module mult_share_ctrl #(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MULT_LAT  = 4,
    parameter  int unsigned RSP_DEPTH = 8,
    localparam int unsigned ID_W      = mult_share_pkg::id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [DATA_W-1:0]         mult_a,
    output logic [DATA_W-1:0]         mult_b,
    input  logic [2*DATA_W-1:0]       mult_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [2*DATA_W-1:0]       rsp_data
);

    import mult_share_pkg::*;

    localparam int unsigned PIPE_D = MULT_LAT + 1;
    localparam int unsigned INF_W  = $clog2(PIPE_D + 1);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned SUM_W  = $clog2(RSP_DEPTH + PIPE_D + 1);

    logic [ID_W-1:0]              rr_q, rr_d;
    logic [DATA_W-1:0]            mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic [PIPE_D-1:0]            tag_vld_q, tag_vld_d;
    logic [PIPE_D-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic [INF_W-1:0]             inflight_q, inflight_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              can_issue, found, push;
    logic [ID_W-1:0]   gid, cand;
    logic [NUM_REQ-1:0] grant;
    rsp_entry_t        push_entry, head_entry;

    // Conservative: a pop in this cycle does not free a credit until next cycle.
    assign can_issue = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(RSP_DEPTH);
    assign push      = tag_vld_q[PIPE_D-1];

    always_comb begin
        found = 1'b0;
        gid   = '0;
        cand  = '0;
        grant = '0;
        if (reset && can_issue) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    gid   = cand;
                end
            end
        end
        if (found) begin
            grant[gid] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_comb begin
        mult_a_d   = '0;
        mult_b_d   = '0;
        rr_d       = rr_q;
        inflight_d = inflight_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                mult_a_d = req_a[i*DATA_W +: DATA_W];
                mult_b_d = req_b[i*DATA_W +: DATA_W];
            end
        end
        if (found) begin
            rr_d = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + ID_W'(1);
        end
        if (found && !push) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!found && push) begin
            inflight_d = inflight_q - INF_W'(1);
        end
        tag_vld_d = {tag_vld_q[PIPE_D-2:0], found};
        tag_id_d  = {tag_id_q[PIPE_D-2:0], gid};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q       <= '0;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
        end else begin
            rr_q       <= rr_d;
            mult_a_q   <= mult_a_d;
            mult_b_q   <= mult_b_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
        end
    end

    assign mult_a = mult_a_q;
    assign mult_b = mult_b_q;

    always_comb begin
        push_entry      = '0;
        push_entry.id   = tag_id_q[PIPE_D-1];
        push_entry.data = mult_result;
    end

    mult_share_rsp_fifo #(
        .Width ($bits(rsp_entry_t)),
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (rsp_ready),
        .valid_o (rsp_valid),
        .rdata_o (head_entry),
        .count_o (fifo_count)
    );

    assign rsp_id   = head_entry.id;
    assign rsp_data = head_entry.data;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl beside the real 4-stage multiplier.
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_result;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;

    always #5 clk = ~clk;

    mult_share_ctrl #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MULT_LAT  (4),
        .RSP_DEPTH (8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data)
    );

    mult #(.DATA_W(8)) u_mult (
        .clk    (clk),
        .reset  (~reset),
        .a      (mult_a),
        .b      (mult_b),
        .result (mult_result)
    );

    typedef struct { logic [1:0] id; logic [15:0] data; } exp_t;
    typedef struct { logic [3:0] valid; logic rdy; logic [3:0] exp_grant; } vec_t;

    exp_t       expq[$];
    vec_t       vecs[13];
    logic [7:0] op_a[4], op_b[4];
    int errors = 0, checks = 0, accepts = 0, pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    // One clock: drive, settle, score accepts/responses, then advance past the edge.
    task automatic step(input logic [3:0] v, input logic rr, output logic [3:0] g);
        exp_t e;
        req_valid = v;
        rsp_ready = rr;
        #1;
        g = req_ready;
        check("grant_legal", 32'(((req_ready & ~req_valid) == 4'b0) && $onehot0(req_ready)), 1);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id   = 2'(i);
                e.data = 16'(op_a[i]) * 16'(op_b[i]);
                expq.push_back(e);
                accepts++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            pops++;
            if (expq.size() == 0) begin
                check("no_stale_rsp", 1, 0);
            end else begin
                e = expq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        expq.delete();
    endtask

    task automatic wait_rsp(output int lat);
        logic [3:0] g;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step(4'b0, 1'b0, g);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        int lat, base, stale;
        reset = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        for (int i = 0; i < 8; i++) vecs[i] = '{4'hF, 1'b1, 4'(1 << (i % 4))};
        vecs[8]  = '{4'b0101, 1'b1, 4'b0001};
        vecs[9]  = '{4'b0101, 1'b1, 4'b0100};
        vecs[10] = '{4'b0101, 1'b1, 4'b0001};
        vecs[11] = '{4'b1000, 1'b1, 4'b1000};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_mult_a", 32'(mult_a), 0);
        check("rst_mult_b", 32'(mult_b), 0);
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single request latency.
        set_ops(0, 8'd200, 8'd100);
        step(4'b0001, 1'b1, g);
        check("t1_grant", 32'(g), 1);
        check("t1_mult_a", 32'(mult_a), 200);
        wait_rsp(lat);
        check("t1_latency", 32'(lat), 5);
        check("t1_id", 32'(rsp_id), 0);
        check("t1_data", 32'(rsp_data), 32'h4E20);
        repeat (6) step(4'b0, 1'b1, g);
        check("t1_drained", 32'(expq.size()), 0);
        check("t1_idle", 32'(rsp_valid), 0);

        // Round-robin table including skip and wrap.
        do_reset();
        reset = 1'b1;
        set_ops(0, 8'd12, 8'd34);
        set_ops(1, 8'd56, 8'd78);
        set_ops(2, 8'd255, 8'd255);
        set_ops(3, 8'd0, 8'd77);
        base = pops;
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].valid, vecs[i].rdy, g);
            check($sformatf("vec%0d_grant", i), 32'(g), 32'(vecs[i].exp_grant));
        end
        repeat (10) step(4'b0, 1'b1, g);
        check("t2_pops", 32'(pops - base), 12);
        check("t2_drained", 32'(expq.size()), 0);

        // Edge operands, checked against hand values.
        step(4'b0100, 1'b0, g);
        check("t4_grant2", 32'(g), 32'b0100);
        step(4'b1000, 1'b0, g);
        check("t4_grant3", 32'(g), 32'b1000);
        wait_rsp(lat);
        check("t4_id_ff", 32'(rsp_id), 2);
        check("t4_data_ff", 32'(rsp_data), 32'hFE01);
        step(4'b0, 1'b1, g);
        check("t4_valid_zero", 32'(rsp_valid), 1);
        check("t4_id_zero", 32'(rsp_id), 3);
        check("t4_data_zero", 32'(rsp_data), 0);
        step(4'b0, 1'b1, g);

        // Backpressure fills credits, then full-FIFO single pop.
        do_reset();
        reset = 1'b1;
        base = accepts;
        repeat (16) step(4'hF, 1'b0, g);
        check("t3_accepts", 32'(accepts - base), 8);
        check("t3_blocked", 32'(g), 0);
        check("t3_rsp_valid", 32'(rsp_valid), 1);
        base = pops;
        step(4'hF, 1'b1, g);
        check("t5_full_nogrant", 32'(g), 0);
        step(4'hF, 1'b0, g);
        check("t5_one_grant", 32'(g), 32'b0001);
        step(4'hF, 1'b0, g);
        check("t5_no_second", 32'(g), 0);
        repeat (20) step(4'b0, 1'b1, g);
        check("t3_pops", 32'(pops - base), 9);
        check("t3_drained", 32'(expq.size()), 0);
        step(4'hF, 1'b1, g);
        check("t3_resume", 32'(g), 32'b0010);
        repeat (8) step(4'b0, 1'b1, g);

        // Reset with results in flight and queued.
        do_reset();
        reset = 1'b1;
        repeat (5) step(4'hF, 1'b0, g);
        repeat (2) step(4'b0, 1'b0, g);
        check("t6_queued", 32'(rsp_valid), 1);
        do_reset();
        check("t6_rsp_cleared", 32'(rsp_valid), 0);
        reset = 1'b1;
        stale = 0;
        repeat (10) begin
            if (rsp_valid) stale++;
            step(4'b0, 1'b1, g);
        end
        check("t6_no_stale", 32'(stale), 0);
        step(4'b0001, 1'b0, g);
        check("t6_grant", 32'(g), 1);
        wait_rsp(lat);
        check("t6_latency", 32'(lat), 5);
        check("t6_data", 32'(rsp_data), 32'h0198);
        repeat (4) step(4'b0, 1'b1, g);
        check("t6_drained", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
